// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key schedule shared types, S-box and Rcon tables
package aes_pkg;

    typedef logic [127:0] block_t;

    localparam int NUM_ROUNDS = 10;

    // Byte 0 of the table sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Rounds outside 1..10 have no constant; zero keeps the idle datapath quiet.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r == 4'd0 || r > 4'd10) begin
            return 8'h00;
        end
        return RCON_TABLE[(10 - int'(r)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/key_expand_round.sv
// rtl/key_expand_round.sv - one combinational AES-128 key expansion round
module key_expand_round
    import aes_pkg::*;
(
    input  block_t     prev_key_i,
    input  logic [7:0] rcon_i,
    output block_t     next_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w;
    logic [31:0] w4, w5, w6, w7;

    assign {w0, w1, w2, w3} = prev_key_i;

    assign rot_w = {w3[23:0], w3[31:24]};
    assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                    sbox(rot_w[15:8]),  sbox(rot_w[7:0])};

    assign w4 = w0 ^ sub_w ^ {rcon_i, 24'h000000};
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    assign next_key_o = {w4, w5, w6, w7};

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - AES-128 round key store, one round per cycle; KEY_SCHEDULE_ZEROIZE_EN adds zeroize
module key_schedule
    import aes_pkg::*;
(
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         keys_valid,
    output logic         done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       done_q, done_d;
    logic       load_key;
    logic       zero_req;
    block_t     slot_q [NUM_ROUNDS+1];
    block_t     next_key;

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    key_expand_round u_round (
        .prev_key_i (slot_q[rnd_q - 4'd1]),
        .rcon_i     (rcon(rnd_q)),
        .next_key_o (next_key)
    );

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        done_d   = 1'b0;
        load_key = 1'b0;
        if (zero_req) begin
            state_d = S_IDLE;
            rnd_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        load_key = 1'b1;
                        rnd_d    = 4'd1;
                        state_d  = S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (rnd_q == 4'(NUM_ROUNDS)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rnd_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
            if (zero_req) begin
                for (int i = 0; i <= NUM_ROUNDS; i++) begin
                    slot_q[i] <= '0;
                end
            end else if (load_key) begin
                slot_q[0] <= key;
            end else if (state_q == S_EXPAND) begin
                slot_q[rnd_q] <= next_key;
            end
        end
    end

    assign rd_key     = (rd_round > 4'(NUM_ROUNDS)) ? '0 : slot_q[rd_round];
    assign busy       = (state_q == S_EXPAND);
    assign keys_valid = (state_q == S_DONE);
    assign done       = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - scoreboard bench for key_schedule; KEY_SCHEDULE_ZEROIZE_EN enables the zeroize case
module tb_key_schedule;

    typedef struct packed {
        logic [1407:0] rk;
        logic [31:0]   start_cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         busy;
    logic         keys_valid;
    logic         done;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    logic         zeroize;
`endif

    logic [3:0]   mon_rd, stim_rd;
    logic         mon_active;
    logic [7:0]   sb [256];
    exp_t         exp_q [$];
    int           cyc;
    int           n_checks;
    int           n_fail;

    assign rd_round = mon_active ? mon_rd : stim_rd;

    key_schedule dut (
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] model_keys(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    task automatic issue_start(input logic [127:0] k);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        key   = k;
        e.rk        = model_keys(k);
        e.start_cyc = 32'(cyc + 1);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", 128'(n < 100), 128'd1);
    endtask

    task automatic check_all_zero(input string name);
        for (int r = 0; r < 16; r++) begin
            stim_rd = 4'(r);
            #1;
            chk($sformatf("%s_r%0d", name, r), rd_key, 128'd0);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected expansion.
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_rd     = 4'd0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no expansion at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", 128'(cyc - int'(e.start_cyc)), 128'd10);
                    chk("keys_valid_at_done", 128'(keys_valid), 128'd1);
                    chk("busy_at_done", 128'(busy), 128'd0);
                    @(negedge clk);
                    chk("done_one_cycle", 128'(done), 128'd0);
                    for (int r = 0; r < 16; r++) begin
                        mon_rd = 4'(r);
                        #1;
                        chk($sformatf("rd_key_r%0d", r), rd_key, (r <= 10) ? e.rk[r*128 +: 128] : 128'd0);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        stim_rd  = 4'd0;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
        zeroize  = 1'b0;
`endif
        build_sbox();
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_keys_valid", 128'(keys_valid), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        check_all_zero("reset_slot");
        @(negedge clk);
        rst = 1'b0;

        issue_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_idle();
        stim_rd = 4'd1;
        #1 chk("fips_r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        stim_rd = 4'd10;
        #1 chk("fips_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        issue_start(128'd0);
        wait_idle();
        stim_rd = 4'd1;
        #1 chk("zero_r1", rd_key, 128'h62636363626363636263636362636363);
        stim_rd = 4'd10;
        #1 chk("zero_r10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // A second start four cycles into expansion must be ignored.
        issue_start({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(negedge clk);
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", 128'(busy), 128'd1);
        wait_idle();

        // Reset five cycles into expansion.
        issue_start({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_keys_valid", 128'(keys_valid), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        check_all_zero("midrst_slot");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst_busy", 128'(busy), 128'd0);
        chk("idle_after_rst_valid", 128'(keys_valid), 128'd0);
        issue_start({$urandom, $urandom, $urandom, $urandom});
        wait_idle();

        // Start in DONE: keys_valid low for ten cycles, then high.
        issue_start({$urandom, $urandom, $urandom, $urandom});
        chk("redo_valid_c1", 128'(keys_valid), 128'd0);
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("redo_valid_c%0d", c), 128'(keys_valid), 128'd0);
        end
        @(negedge clk);
        chk("redo_valid_high", 128'(keys_valid), 128'd1);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_start({$urandom, $urandom, $urandom, $urandom});
            wait_idle();
        end

`ifdef KEY_SCHEDULE_ZEROIZE_EN
        @(negedge clk);
        start   = 1'b1;
        zeroize = 1'b1;
        key     = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start   = 1'b0;
        zeroize = 1'b0;
        chk("zeroize_busy", 128'(busy), 128'd0);
        chk("zeroize_keys_valid", 128'(keys_valid), 128'd0);
        check_all_zero("zeroize_slot");
        repeat (12) @(negedge clk);
        chk("zeroize_stays_idle", 128'(busy | keys_valid | done), 128'd0);
        issue_start({$urandom, $urandom, $urandom, $urandom});
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
